thumb_issue_ctrl: RTL and testbench

THUMB_ISSUE_CTRL -- requirements
Module: thumb_issue_ctrl

---
 rtl/thumb_issue_ctrl.sv | 113 +++++++++++
 tb/tb_thumb_issue_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_issue_ctrl.sv
// Thumb halfword-to-instruction assembler between fetch and decode.
// Optional issue counters are enabled by defining ISSUE_PERF_CNT_EN.
module thumb_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        hw_valid,
  input  logic [15:0] hw_data,
  output logic        hw_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        inst_is32,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0] issue_cnt,
  output logic [31:0] issue32_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, HI, OUT} state_t;

  state_t      state_reg;
  logic [15:0] first_reg;
  logic [31:0] first_pc_reg;
  logic [31:0] fetch_pc_reg;

  logic hw_is32;
  logic hw_xfer;
  logic inst_xfer;
  logic unused_bits;

  // Prefixes 11101, 11110 and 11111 open a 32-bit encoding.
  assign hw_is32     = (hw_data[15:13] == 3'b111) && (hw_data[12:11] != 2'b00);
  assign hw_ready    = !rst && !flush && ((state_reg != OUT) || inst_ready);
  assign hw_xfer     = hw_valid && hw_ready;
  assign inst_xfer   = inst_valid && inst_ready && !rst && !flush;
  assign unused_bits = flush_pc[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      first_reg    <= 16'h0;
      first_pc_reg <= 32'h0;
      fetch_pc_reg <= 32'h0;
      inst_valid   <= 1'b0;
      inst         <= 32'h0;
      inst_is32    <= 1'b0;
      inst_pc      <= 32'h0;
    end else if (flush) begin
      state_reg    <= EMPTY;
      inst_valid   <= 1'b0;
      fetch_pc_reg <= {flush_pc[31:1], 1'b0};
    end else begin
      if (hw_xfer) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd2;
      end
      case (state_reg)
        EMPTY, OUT: begin
          // In OUT a halfword only transfers when the decoder also takes inst,
          // so a new halfword here gives back-to-back issue.
          if (hw_xfer) begin
            if (hw_is32) begin
              first_reg    <= hw_data;
              first_pc_reg <= fetch_pc_reg;
              state_reg    <= HI;
              inst_valid   <= 1'b0;
            end else begin
              inst       <= {hw_data, 16'h0};
              inst_is32  <= 1'b0;
              inst_pc    <= fetch_pc_reg;
              state_reg  <= OUT;
              inst_valid <= 1'b1;
            end
          end else if ((state_reg == OUT) && inst_ready) begin
            state_reg  <= EMPTY;
            inst_valid <= 1'b0;
          end
        end
        HI: begin
          if (hw_xfer) begin
            inst       <= {first_reg, hw_data};
            inst_is32  <= 1'b1;
            inst_pc    <= first_pc_reg;
            state_reg  <= OUT;
            inst_valid <= 1'b1;
          end
        end
        default: begin
          state_reg  <= EMPTY;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt   <= 32'h0;
      issue32_cnt <= 32'h0;
    end else if (inst_xfer) begin
      issue_cnt <= issue_cnt + 32'd1;
      if (inst_is32) begin
        issue32_cnt <= issue32_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_thumb_issue_ctrl.sv
// Directed bench for thumb_issue_ctrl; expected issues are queued at drive time
// and popped when the decoder handshake completes.
module tb_thumb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hw_valid;
  logic [15:0] hw_data;
  logic        hw_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_is32;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] issue_cnt;
  logic [31:0] issue32_cnt;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic        is32;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  thumb_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .hw_valid   (hw_valid),
    .hw_data    (hw_data),
    .hw_ready   (hw_ready),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_is32  (inst_is32),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .issue_cnt  (issue_cnt),
    .issue32_cnt(issue32_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hw(input logic [15:0] d);
    hw_valid = 1'b1;
    hw_data  = d;
  endtask

  task automatic idle_hw();
    hw_valid = 1'b0;
    hw_data  = 16'($urandom);
  endtask

  task automatic push(input logic [31:0] i, input logic is32, input logic [31:0] pc);
    exp_t e;
    e.inst = i;
    e.is32 = is32;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    flush = 1'b0;
    idle_hw();
    cyc();
    rst = 1'b0;
  endtask

  // Scoreboard: every decoder transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && !flush && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_inst", inst, e.inst);
        chk("sb_is32", {31'd0, inst_is32}, {31'd0, e.is32});
        chk("sb_pc", inst_pc, e.pc);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = 32'h0; inst_ready = 1'b1;
    idle_hw();
    cyc();
    cyc();
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_is32", {31'd0, inst_is32}, 32'd0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_hw_ready", {31'd0, hw_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("hw_ready_empty", {31'd0, hw_ready}, 32'd1);

    // Single 16-bit instruction, one-cycle latency.
    drive_hw(16'h4148); push(32'h41480000, 1'b0, 32'h0);
    cyc();
    idle_hw();
    chk("lat16_valid", {31'd0, inst_valid}, 32'd1);
    chk("lat16_inst", inst, 32'h41480000);
    cyc();
    chk("lat16_drop", {31'd0, inst_valid}, 32'd0);

    // 32-bit pair.
    reset_dut();
    drive_hw(16'hF141);
    cyc();
    chk("hi_valid", {31'd0, inst_valid}, 32'd0);
    drive_hw(16'h0A05); push(32'hF1410A05, 1'b1, 32'h0);
    cyc();
    idle_hw();
    chk("pair_valid", {31'd0, inst_valid}, 32'd1);
    chk("pair_is32", {31'd0, inst_is32}, 32'd1);
    cyc();

    // Four back-to-back 16-bit halfwords.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive_hw(16'h2000 + 16'(i)); push({16'h2000 + 16'(i), 16'h0}, 1'b0, 32'(2 * i));
      cyc();
      chk("stream_valid", {31'd0, inst_valid}, 32'd1);
      chk("stream_pc", inst_pc, 32'(2 * i));
    end

    // Decoder stall holds outputs and back-pressures fetch.
    drive_hw(16'h4600); push(32'h46000000, 1'b0, 32'h8);
    cyc();
    inst_ready = 1'b0;
    drive_hw(16'h1C0A);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_hw_ready", {31'd0, hw_ready}, 32'd0);
      chk("stall_inst", inst, 32'h46000000);
      chk("stall_pc", inst_pc, 32'h8);
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      cyc();
    end
    inst_ready = 1'b1;
    #1;
    chk("unstall_hw_ready", {31'd0, hw_ready}, 32'd1);
    push(32'h1C0A0000, 1'b0, 32'hA);
    cyc();
    idle_hw();
    chk("unstall_inst", inst, 32'h1C0A0000);
    cyc();

    // Classification boundaries; second half is taken verbatim.
    drive_hw(16'hE7FF); push(32'hE7FF0000, 1'b0, 32'hC);
    cyc();
    drive_hw(16'hE800);
    cyc();
    chk("e800_is_hi", {31'd0, inst_valid}, 32'd0);
    drive_hw(16'hF800); push(32'hE800F800, 1'b1, 32'hE);
    cyc();
    drive_hw(16'hFFFF);
    cyc();
    chk("ffff_is_hi", {31'd0, inst_valid}, 32'd0);
    drive_hw(16'hE000); push(32'hFFFFE000, 1'b1, 32'h12);
    cyc();
    idle_hw();
    chk("ffff_pair_is32", {31'd0, inst_is32}, 32'd1);
    cyc();

    // Flush while holding a first half.
    drive_hw(16'hF141);
    cyc();
    flush = 1'b1; flush_pc = 32'h00000101; drive_hw(16'h4148);
    #1;
    chk("flush_hw_ready", {31'd0, hw_ready}, 32'd0);
    cyc();
    flush = 1'b0;
    chk("flush_valid", {31'd0, inst_valid}, 32'd0);
    drive_hw(16'h4148); push(32'h41480000, 1'b0, 32'h100);
    cyc();
    idle_hw();
    chk("flush_pc", inst_pc, 32'h100);
    cyc();

    // Flush in OUT with decoder ready: no transfer; then address wrap.
    drive_hw(16'h1111);
    cyc();
    flush = 1'b1; flush_pc = 32'hFFFFFFFF; idle_hw();
    cyc();
    flush = 1'b0;
    chk("flush_out_valid", {31'd0, inst_valid}, 32'd0);
    drive_hw(16'h2222); push(32'h22220000, 1'b0, 32'hFFFFFFFE);
    cyc();
    drive_hw(16'h3333); push(32'h33330000, 1'b0, 32'h0);
    cyc();
    idle_hw();
    chk("wrap_pc", inst_pc, 32'h0);
    cyc();

    // Reset while OUT discards the instruction.
    drive_hw(16'h5555);
    cyc();
    rst = 1'b1; idle_hw();
    cyc();
    chk("rst_out_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_out_inst", inst, 32'h0);
    rst = 1'b0;

`ifdef ISSUE_PERF_CNT_EN
    reset_dut();
    drive_hw(16'h4148); push(32'h41480000, 1'b0, 32'h0);
    cyc();
    drive_hw(16'hF141);
    cyc();
    drive_hw(16'h0A05); push(32'hF1410A05, 1'b1, 32'h2);
    cyc();
    drive_hw(16'hF000);
    cyc();
    drive_hw(16'hF800); push(32'hF000F800, 1'b1, 32'h6);
    cyc();
    idle_hw();
    cyc();
    chk("issue_cnt", issue_cnt, 32'd3);
    chk("issue32_cnt", issue32_cnt, 32'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("issue_cnt_rst", issue_cnt, 32'd0);
    chk("issue32_cnt_rst", issue32_cnt, 32'd0);
`endif

    cyc();
    cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
